// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared pipeline definitions: multiply/divide sequencer states and EX operand
// forwarding selects, also used by the EX stage operand mux.
package ex_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } md_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // A later stage will write the register being read (x0 never forwards).
  function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface ex_hazard_ctrl_if;
  logic [4:0] id_ex_rs1;
  logic [4:0] id_ex_rs2;
  logic [4:0] id_ex_rd;
  logic       id_ex_mem_read;
  logic       id_ex_is_md;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic [4:0] ex_mem_rd;
  logic [4:0] mem_wb_rd;
  logic       ex_mem_reg_write;
  logic       mem_wb_reg_write;
  logic       flush_i;
  logic       md_done;
  logic [1:0] forwardA;
  logic [1:0] forwardB;
  logic       md_start;
  logic       md_kill;
  logic       stall_pc_if_id;
  logic       bubble_id_ex;
  logic       hold_ex;
  logic       md_result_sel;
  logic       md_error;

  modport master (
    output id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_mem_read, id_ex_is_md,
           if_id_rs1, if_id_rs2, ex_mem_rd, mem_wb_rd,
           ex_mem_reg_write, mem_wb_reg_write, flush_i, md_done,
    input  forwardA, forwardB, md_start, md_kill, stall_pc_if_id,
           bubble_id_ex, hold_ex, md_result_sel, md_error
  );

  modport slave (
    input  id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_mem_read, id_ex_is_md,
           if_id_rs1, if_id_rs2, ex_mem_rd, mem_wb_rd,
           ex_mem_reg_write, mem_wb_reg_write, flush_i, md_done,
    output forwardA, forwardB, md_start, md_kill, stall_pc_if_id,
           bubble_id_ex, hold_ex, md_result_sel, md_error
  );
endinterface

// File: rtl/ex_hazard_ctrl_fwd_unit.sv
// Purely combinational register-index comparisons: EX operand forwarding
// selects and load-use detection against the instruction in ID.
module fwd_unit
  import ex_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_ex_rs1,
  input  logic [4:0] id_ex_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_read,
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic [4:0] ex_mem_rd,
  input  logic [4:0] mem_wb_rd,
  input  logic       ex_mem_reg_write,
  input  logic       mem_wb_reg_write,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b,
  output logic       load_use
);

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  always_comb begin
    forward_a = FWD_RF;
    if (reg_hit(ex_mem_reg_write, ex_mem_rd, id_ex_rs1))
      forward_a = FWD_MEM;
    else if (reg_hit(mem_wb_reg_write, mem_wb_rd, id_ex_rs1))
      forward_a = FWD_WB;
  end

  always_comb begin
    forward_b = FWD_RF;
    if (reg_hit(ex_mem_reg_write, ex_mem_rd, id_ex_rs2))
      forward_b = FWD_MEM;
    else if (reg_hit(mem_wb_reg_write, mem_wb_rd, id_ex_rs2))
      forward_b = FWD_WB;
  end

  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding/load-use via fwd_unit plus the
// multiply/divide issue sequencer with its timeout counter.
//
//   state | meaning
//   IDLE  | no md operation in flight; watch EX for an md instruction
//   ISSUE | md_start launched this cycle; EX held
//   WAIT  | waiting for md_done; EX held; timeout counter running
//   DONE  | EX/MEM captures the md result this cycle
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input logic          clk,
  input logic          reset,
  ex_hazard_ctrl_if.slave hz
);

  md_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               md_error_q;
  logic               kill_q;
  logic               load_use;
  logic               busy;

  fwd_unit u_fwd (
    .id_ex_rs1        (hz.id_ex_rs1),
    .id_ex_rs2        (hz.id_ex_rs2),
    .id_ex_rd         (hz.id_ex_rd),
    .id_ex_mem_read   (hz.id_ex_mem_read),
    .if_id_rs1        (hz.if_id_rs1),
    .if_id_rs2        (hz.if_id_rs2),
    .ex_mem_rd        (hz.ex_mem_rd),
    .mem_wb_rd        (hz.mem_wb_rd),
    .ex_mem_reg_write (hz.ex_mem_reg_write),
    .mem_wb_reg_write (hz.mem_wb_reg_write),
    .forward_a        (hz.forwardA),
    .forward_b        (hz.forwardB),
    .load_use         (load_use)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  // A timeout raises md_error and a registered md_kill in the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      md_error_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      kill_q <= 1'b0;
      case (state)
        IDLE: begin
          if (hz.id_ex_is_md && !hz.flush_i)
            state <= ISSUE;
        end
        ISSUE: begin
          if (hz.flush_i) begin
            state <= IDLE;
          end else begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (hz.flush_i) begin
            state <= IDLE;
          end else if (hz.md_done) begin
            state <= DONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_W'(MD_TIMEOUT)) begin
              state      <= IDLE;
              md_error_q <= 1'b1;
              kill_q     <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == ISSUE) || (state == WAIT);

  // A flush releases the held stages in the same cycle it kills the unit.
  assign hz.md_start       = !reset && (state == ISSUE) && !hz.flush_i;
  assign hz.md_kill        = !reset && (kill_q || (busy && hz.flush_i));
  assign hz.hold_ex        = !reset && busy && !hz.flush_i;
  assign hz.stall_pc_if_id = !reset && (busy ? !hz.flush_i : load_use);
  assign hz.bubble_id_ex   = !reset && !busy && load_use;
  assign hz.md_result_sel  = !reset && (state == DONE) && !hz.flush_i;
  assign hz.md_error       = md_error_q;

endmodule

// File: doc/ex_hazard_ctrl.md
EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 Parameter MD_TIMEOUT, default 64, maximum cycles to wait for md_done before flagging an error.
REQ-002 Parameter CNT_W, default 7, width of the timeout counter; it SHALL hold MD_TIMEOUT.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_ex_rs1, id_ex_rs2, id_ex_rd  in  5 each  register indices of the instruction in EX.
REQ-006 id_ex_mem_read  in  1  EX instruction is a load.
REQ-007 id_ex_is_md  in  1  EX instruction is a multi-cycle multiply/divide.
REQ-008 if_id_rs1, if_id_rs2  in  5 each  source indices of the instruction in ID.
REQ-009 ex_mem_rd, mem_wb_rd  in  5 each  destination indices in MEM and WB.
REQ-010 ex_mem_reg_write, mem_wb_reg_write  in  1 each  MEM and WB write enables.
REQ-011 flush_i  in  1  branch/jump redirect that kills the EX instruction.
REQ-012 md_done  in  1  one-cycle completion pulse from the multiply/divide unit.
REQ-013 forwardA, forwardB  out  2 each  EX operand forwarding selects: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-014 md_start  out  1  one-cycle launch pulse to the multiply/divide unit.
REQ-015 md_kill  out  1  one-cycle abort pulse to the multiply/divide unit.
REQ-016 stall_pc_if_id  out  1  hold PC and IF/ID.
REQ-017 bubble_id_ex  out  1  insert a NOP into ID/EX.
REQ-018 hold_ex  out  1  freeze ID/EX and block the EX/MEM update.
REQ-019 md_result_sel  out  1  EX/MEM captures the multiply/divide result instead of the ALU result.
REQ-020 md_error  out  1  sticky timeout flag.

Function
REQ-021 Forwarding SHALL be combinational:
- forwardA = 10 when ex_mem_reg_write, ex_mem_rd != 0 and ex_mem_rd == id_ex_rs1;
- else 01 when the same conditions hold on the MEM/WB inputs;
- else 00.
- forwardB SHALL follow the same rule using id_ex_rs2.
- EX/MEM SHALL have priority over MEM/WB.
REQ-022 Load-use: when id_ex_mem_read, id_ex_rd != 0 and id_ex_rd matches if_id_rs1 or if_id_rs2, stall_pc_if_id and bubble_id_ex SHALL both be 1 in that same cycle; the combinational path SHALL add no latency.
REQ-023 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-024 IDLE->ISSUE when id_ex_is_md=1 and flush_i=0.
REQ-025 ISSUE: md_start=1 for exactly one cycle, then go to WAIT.
REQ-026 WAIT->DONE on md_done.
REQ-027 DONE: md_result_sel=1 for exactly one cycle, then go to IDLE.
REQ-028 In ISSUE and WAIT, hold_ex=1 and stall_pc_if_id=1; bubble_id_ex=0.
REQ-029 An md_done arriving in ISSUE SHALL be ignored.
REQ-030 In DONE, hold_ex=0 so EX/MEM captures the result; an IF/ID load-use match in that cycle SHALL still stall per REQ-022.
REQ-031 flush_i in ISSUE or WAIT SHALL:
- pulse md_kill for one cycle;
- return the FSM to IDLE on the next edge;
- drop hold_ex and stall_pc_if_id in the flush cycle.
REQ-032 flush_i in DONE SHALL force md_result_sel=0 and return to IDLE.
REQ-033 flush_i in IDLE SHALL suppress the IDLE->ISSUE transition.
REQ-034 The timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-035 When the counter reaches MD_TIMEOUT, the block SHALL:
- set md_error;
- pulse md_kill;
- go to IDLE.
md_error SHALL remain set until reset.
REQ-036 After DONE, a back-to-back md instruction in EX SHALL re-enter ISSUE from IDLE on the following cycle; there is no direct DONE->ISSUE transition.

Reset
REQ-037 reset SHALL force: state IDLE, timeout counter 0, md_error 0.
REQ-038 During reset, md_start, md_kill, md_result_sel, hold_ex, stall_pc_if_id and bubble_id_ex SHALL all be 0; forwardA/forwardB SHALL remain combinational.
REQ-039 reset asserted in WAIT SHALL return the FSM to IDLE without an md_kill pulse; the unit is reset in parallel.

Structure
REQ-040 State encodings and the forwarding-select constants FWD_RF=00, FWD_MEM=10, FWD_WB=01 SHALL live in the shared pipeline package, also used by the EX stage mux.
REQ-041 Forwarding/load-use comparison logic SHALL be one sub-module, fwd_unit; the FSM and counter SHALL live in ex_hazard_ctrl.

Verification
REQ-042 ex_mem_rd=5, ex_mem_reg_write=1, mem_wb_rd=5, mem_wb_reg_write=1, id_ex_rs1=5 -> forwardA=10; with rd=0 on both -> forwardA=00.
REQ-043 Load with id_ex_rd=3, if_id_rs2=3 -> stall_pc_if_id=1 and bubble_id_ex=1 for exactly 1 cycle.
REQ-044 md instruction, md_done 10 cycles after md_start -> hold_ex=1 for 11 cycles, then md_result_sel=1 for 1 cycle, then IDLE.
REQ-045 flush_i in the 4th WAIT cycle -> md_kill=1 for 1 cycle, IDLE next edge, no md_result_sel.
REQ-046 MD_TIMEOUT=8 with no md_done -> md_error=1 and md_kill pulse after 8 WAIT cycles; md_error stays 1 until reset.
REQ-047 reset in WAIT -> next cycle: IDLE, all control outputs 0, md_error=0.
